// File: rtl/fetch.sv
// IF stage: owns the PC, drives ibus read requests and buffers up to two
// fetched instructions for decode, with stall back-pressure and redirects.
package fetch_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;
endpackage

module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h8000_0000,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output fetch_data_t dataF,
  output logic        valid_f,
  input  logic        stall,
  input  logic        jump,
  input  logic [63:0] pcsrc
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    KILL
  } state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [63:0] req_addr;
  logic [63:0] pc_inc;
  fetch_data_t q0;
  fetch_data_t q1;
  fetch_data_t wdata;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        pop;
  logic        push;
  logic        redirect;

  assign valid_f    = (count != 2'd0);
  assign dataF      = q0;
  assign pop        = valid_f & ~stall;
  assign redirect   = pop & jump;
  assign push       = (state == FETCH) & iresp_data_ok & ~redirect;
  assign pc_inc     = fetch_pc + PC_STEP;
  assign wdata      = {req_addr, iresp_data};
  // request is masked while reset is held so the bus sees no read
  assign ireq_valid = reset & (state != WAIT);
  assign ireq_addr  = req_addr;

  always_comb begin
    count_next = count;
    unique case (1'b1)
      redirect:
        count_next = 2'd0;
      push & ~pop:
        count_next = count + 2'd1;
      pop & ~push & ~redirect:
        count_next = count - 2'd1;
      default: ;
    endcase
  end

  // q0 is the head; when the FIFO drains it keeps its last value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0    <= '0;
      q1    <= '0;
      count <= 2'd0;
    end else begin
      count <= count_next;
      if (pop && count == 2'd2)
        q0 <= q1;
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop))
          q0 <= wdata;
        else
          q1 <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      fetch_pc <= PC_RESET;
      req_addr <= PC_RESET;
    end else begin
      unique case (state)
        FETCH: begin
          if (redirect) begin
            fetch_pc <= pcsrc;
            if (iresp_data_ok)
              req_addr <= pcsrc;
            else
              state <= KILL;
          end else if (iresp_data_ok) begin
            fetch_pc <= pc_inc;
            req_addr <= pc_inc;
            if (count_next == 2'd2)
              state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= pcsrc;
            req_addr <= pcsrc;
            state    <= FETCH;
          end else if (count_next != 2'd2) begin
            req_addr <= fetch_pc;
            state    <= FETCH;
          end
        end
        KILL: begin
          // stale read must finish on the bus before refetching
          if (redirect)
            fetch_pc <= pcsrc;
          if (iresp_data_ok) begin
            req_addr <= redirect ? pcsrc : fetch_pc;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
